wbmem_window_slave: RTL and testbench

Pipelined Wishbone slave RAM that sits directly downstream of the MMU's physical-side master port.
- Consumes translated physical requests and returns ack, err and read data.
- Decodes a single address window. Any access outside that window is answered with a bus error, so MMU miss/err propagation can be exercised.
- Optional periodic stall injection exercises the MMU's stall handling.

---
 rtl/wbmem_window_slave_if.sv | 30 +++
 rtl/wbmem_window_slave.sv | 117 +++++++++++
 tb/tb_wbmem_window_slave.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wbmem_window_slave_if.sv
// rtl/wbmem_window_slave_if.sv - Wishbone pipelined bus bundle between MMU physical port and RAM slave
//
// Purpose : groups the Wishbone request/response signals of the physical-side bus.
// Signals : i_wb_cyc/i_wb_stb/i_wb_we/i_wb_addr/i_wb_data/i_wb_sel  (master -> slave)
//           o_wb_stall/o_wb_ack/o_wb_err/o_wb_data                  (slave -> master)
// Modports: master drives the requests, slave drives the responses.
interface wbmem_window_slave_if #(
    parameter int AW = 30
);
    logic          i_wb_cyc;
    logic          i_wb_stb;
    logic          i_wb_we;
    logic [AW-1:0] i_wb_addr;
    logic [31:0]   i_wb_data;
    logic [3:0]    i_wb_sel;
    logic          o_wb_stall;
    logic          o_wb_ack;
    logic          o_wb_err;
    logic [31:0]   o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/wbmem_window_slave.sv
// rtl/wbmem_window_slave.sv - pipelined Wishbone RAM slave with single address window and stall injection
//
// Purpose : answers physical-side Wishbone requests from a 2**LGMEMSZ x 32-bit RAM.
//           Accesses whose upper address bits differ from BASE get a bus error; after
//           an error every further strobe in the same cycle is silently absorbed.
//           With STALL_PERIOD=N>0 one stall cycle follows every N accepted strobes.
// Ports   : i_clk   - clock
//           i_reset - synchronous, active-high reset
//           wb      - slave side of the Wishbone bundle (stall/ack/err/data registered)
module wbmem_window_slave #(
    parameter int AW           = 30,
    parameter int LGMEMSZ      = 15,
    parameter int BASE         = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    wbmem_window_slave_if.slave   wb
);
    localparam int              IW     = AW - LGMEMSZ;
    localparam logic [IW-1:0]   BASE_W = IW'(BASE);
    localparam logic [31:0]     N      = 32'(STALL_PERIOD);

    logic [31:0] mem [0:(1<<LGMEMSZ)-1];

    logic        stall_q, stall_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        err_flag_q, err_flag_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;

    logic               accept;
    logic               in_win;
    logic               wr_en;
    logic [LGMEMSZ-1:0] idx;

    assign accept = wb.i_wb_cyc && wb.i_wb_stb && !stall_q;
    assign in_win = (wb.i_wb_addr[AW-1:LGMEMSZ] == BASE_W);
    assign idx    = wb.i_wb_addr[LGMEMSZ-1:0];

    always_comb begin
        ack_d      = 1'b0;
        err_d      = 1'b0;
        stall_d    = 1'b0;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        data_d     = data_q;
        wr_en      = 1'b0;

        if (!wb.i_wb_cyc) begin
            // End of bus cycle: forget the error and restart the stall cadence.
            err_flag_d = 1'b0;
            cnt_d      = '0;
        end else if (err_flag_q) begin
            // Absorb everything until cyc drops.
            cnt_d = '0;
        end else if (accept) begin
            if (in_win) begin
                ack_d = 1'b1;
                if (wb.i_wb_we) begin
                    wr_en = 1'b1;
                end else begin
                    // Writes land at the edge ending the previous accept, so a
                    // read on the following accept already sees the new word.
                    data_d = mem[idx];
                end
                if (N != 32'd0) begin
                    if (cnt_q + 32'd1 >= N) begin
                        cnt_d   = '0;
                        stall_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end else begin
                err_d      = 1'b1;
                err_flag_d = 1'b1;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
            cnt_q      <= '0;
            data_q     <= '0;
        end else begin
            stall_q    <= stall_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.i_wb_sel[b]) begin
                    mem[idx][8*b +: 8] <= wb.i_wb_data[8*b +: 8];
                end
            end
        end
    end

    assign wb.o_wb_stall = stall_q;
    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_err   = err_q;
    assign wb.o_wb_data  = data_q;
endmodule

// File: tb/tb_wbmem_window_slave.sv
// tb/tb_wbmem_window_slave.sv - self-checking bench for wbmem_window_slave
module tb_wbmem_window_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wbmem_window_slave_if #(.AW(30)) bus_a ();
    wbmem_window_slave_if #(.AW(30)) bus_b ();

    wbmem_window_slave #(.AW(30), .LGMEMSZ(15), .BASE(1), .STALL_PERIOD(0)) u_a (
        .i_clk(clk), .i_reset(rst), .wb(bus_a.slave));
    wbmem_window_slave #(.AW(30), .LGMEMSZ(15), .BASE(1), .STALL_PERIOD(2)) u_b (
        .i_clk(clk), .i_reset(rst), .wb(bus_b.slave));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (one slot per DUT) ----------------
    bit          m_flag  [2];
    bit          m_stall [2];
    bit          m_ack   [2];
    bit          m_err   [2];
    bit          m_known [2];
    int unsigned m_cnt   [2];
    bit [31:0]   m_data  [2];
    bit [31:0]   m_mem   [int];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_flag[k] = 0; m_stall[k] = 0; m_ack[k] = 0; m_err[k] = 0;
            m_cnt[k] = 0; m_data[k] = 0; m_known[k] = 1;
        end
    endtask

    task automatic model_step(input int k, input int n, input logic cyc, input logic stb,
                              input logic we, input logic [29:0] addr,
                              input logic [31:0] wd, input logic [3:0] sel);
        bit        acc;
        int        key;
        bit [31:0] w;
        acc = cyc && stb && !m_stall[k];
        m_ack[k] = 0; m_err[k] = 0; m_stall[k] = 0;
        if (!cyc) begin
            m_flag[k] = 0; m_cnt[k] = 0;
        end else if (m_flag[k]) begin
            m_cnt[k] = 0;
        end else if (acc) begin
            if (addr / 32768 == 1) begin
                key = k * 65536 + int'(addr % 32768);
                m_ack[k] = 1;
                if (we) begin
                    if (m_mem.exists(key) || sel == 4'hF) begin
                        w = m_mem.exists(key) ? m_mem[key] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (sel[b]) w[8*b +: 8] = wd[8*b +: 8];
                        m_mem[key] = w;
                    end
                end else begin
                    m_known[k] = m_mem.exists(key);
                    if (m_known[k]) m_data[k] = m_mem[key];
                end
                if (n > 0) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == n) begin
                        m_cnt[k] = 0; m_stall[k] = 1;
                    end
                end
            end else begin
                m_err[k] = 1; m_flag[k] = 1; m_cnt[k] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, 0, bus_a.i_wb_cyc, bus_a.i_wb_stb, bus_a.i_wb_we,
                       bus_a.i_wb_addr, bus_a.i_wb_data, bus_a.i_wb_sel);
            model_step(1, 2, bus_b.i_wb_cyc, bus_b.i_wb_stb, bus_b.i_wb_we,
                       bus_b.i_wb_addr, bus_b.i_wb_data, bus_b.i_wb_sel);
        end
    end

    task automatic cmp(input int k, input logic stall, input logic ack, input logic err,
                       input logic [31:0] data);
        chk($sformatf("m%0d_stall", k), {31'b0, stall}, {31'b0, m_stall[k]});
        chk($sformatf("m%0d_ack", k),   {31'b0, ack},   {31'b0, m_ack[k]});
        chk($sformatf("m%0d_err", k),   {31'b0, err},   {31'b0, m_err[k]});
        chk($sformatf("m%0d_ack_err_excl", k), {31'b0, ack && err}, 32'd0);
        if (m_known[k]) chk($sformatf("m%0d_data", k), data, m_data[k]);
    endtask

    always @(negedge clk) begin
        cmp(0, bus_a.o_wb_stall, bus_a.o_wb_ack, bus_a.o_wb_err, bus_a.o_wb_data);
        cmp(1, bus_b.o_wb_stall, bus_b.o_wb_ack, bus_b.o_wb_err, bus_b.o_wb_data);
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic do_op(input string name, input logic we, input logic [29:0] addr,
                         input logic [31:0] wd, input logic [3:0] sel,
                         input logic exp_ack, input logic exp_err,
                         input logic chk_data, input logic [31:0] exp_data);
        @(negedge clk);
        bus_a.i_wb_cyc = 1; bus_a.i_wb_stb = 1; bus_a.i_wb_we = we;
        bus_a.i_wb_addr = addr; bus_a.i_wb_data = wd; bus_a.i_wb_sel = sel;
        @(negedge clk);
        bus_a.i_wb_stb = 0; bus_a.i_wb_we = 0;
        chk({name, "_ack"}, {31'b0, bus_a.o_wb_ack}, {31'b0, exp_ack});
        chk({name, "_err"}, {31'b0, bus_a.o_wb_err}, {31'b0, exp_err});
        if (chk_data) chk({name, "_data"}, bus_a.o_wb_data, exp_data);
    endtask

    task automatic end_cyc();
        @(negedge clk);
        bus_a.i_wb_cyc = 0; bus_a.i_wb_stb = 0;
    endtask

    int acks, accs, stalls;

    initial begin
        bus_a.i_wb_cyc = 0; bus_a.i_wb_stb = 0; bus_a.i_wb_we = 0;
        bus_a.i_wb_addr = 0; bus_a.i_wb_data = 0; bus_a.i_wb_sel = 0;
        bus_b.i_wb_cyc = 0; bus_b.i_wb_stb = 0; bus_b.i_wb_we = 0;
        bus_b.i_wb_addr = 0; bus_b.i_wb_data = 0; bus_b.i_wb_sel = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_ack",   {31'b0, bus_a.o_wb_ack},   32'd0);
        chk("rst_err",   {31'b0, bus_a.o_wb_err},   32'd0);
        chk("rst_stall", {31'b0, bus_a.o_wb_stall}, 32'd0);
        chk("rst_data",  bus_a.o_wb_data,           32'd0);

        // 1: write then read
        do_op("t1_wr", 1, 30'h8004, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0);
        do_op("t1_rd", 0, 30'h8004, 32'h0, 4'h0, 1, 0, 1, 32'hDEADBEEF);

        // 2: byte selects
        do_op("t2_wr0", 1, 30'h8010, 32'h11223344, 4'hF, 1, 0, 0, 0);
        do_op("t2_wr1", 1, 30'h8010, 32'hAABBCCDD, 4'b0101, 1, 0, 0, 0);
        do_op("t2_rd0", 0, 30'h8010, 32'h0, 4'hF, 1, 0, 1, 32'h11BB33DD);
        do_op("t2_wr2", 1, 30'h8010, 32'hFFFFFFFF, 4'h0, 1, 0, 0, 0);
        do_op("t2_rd1", 0, 30'h8010, 32'h0, 4'h0, 1, 0, 1, 32'h11BB33DD);

        // 3: preload, then pipelined 4-read burst
        for (int i = 0; i < 4; i++)
            do_op("t3_pre", 1, 30'h8000 + 30'(i), 32'h100 + 32'(i), 4'hF, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_idle_ack", {31'b0, bus_a.o_wb_ack}, 32'd0);
            else begin
                chk("t3_burst_ack",  {31'b0, bus_a.o_wb_ack}, 32'd1);
                chk("t3_burst_data", bus_a.o_wb_data, 32'h100 + 32'(i - 1));
            end
            if (i < 4) begin
                bus_a.i_wb_cyc = 1; bus_a.i_wb_stb = 1; bus_a.i_wb_we = 0;
                bus_a.i_wb_addr = 30'h8000 + 30'(i);
            end else bus_a.i_wb_stb = 0;
        end
        // back-to-back write then read of the same word
        @(negedge clk);
        bus_a.i_wb_stb = 1; bus_a.i_wb_we = 1; bus_a.i_wb_addr = 30'h8030;
        bus_a.i_wb_data = 32'hCAFEF00D; bus_a.i_wb_sel = 4'hF;
        @(negedge clk);
        bus_a.i_wb_we = 0;
        @(negedge clk);
        bus_a.i_wb_stb = 0;
        chk("t3_raw_data", bus_a.o_wb_data, 32'hCAFEF00D);
        end_cyc();

        // 4: out-of-window error absorbs the rest of the cycle
        do_op("t4_pre", 1, 30'h8020, 32'h5A5A1234, 4'hF, 1, 0, 0, 0);
        end_cyc();
        do_op("t4_oow", 0, 30'h4000, 32'h0, 4'hF, 0, 1, 0, 0);
        do_op("t4_absorbed", 1, 30'h8020, 32'h00000000, 4'hF, 0, 0, 0, 0);
        end_cyc();
        do_op("t4_reread", 0, 30'h8020, 32'h0, 4'hF, 1, 0, 1, 32'h5A5A1234);
        end_cyc();
        // ack registered just before cyc drops is still driven
        @(negedge clk);
        bus_a.i_wb_cyc = 1; bus_a.i_wb_stb = 1; bus_a.i_wb_we = 0; bus_a.i_wb_addr = 30'h8004;
        @(negedge clk);
        bus_a.i_wb_cyc = 0; bus_a.i_wb_stb = 0;
        chk("t4_late_ack", {31'b0, bus_a.o_wb_ack}, 32'd1);
        @(negedge clk);
        chk("t4_idle_ack", {31'b0, bus_a.o_wb_ack}, 32'd0);

        // 5: stall injection, N=2, strobe held for 6 cycles
        acks = 0; accs = 0; stalls = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c > 0 && bus_b.o_wb_ack) acks++;
            if (c < 6) begin
                chk("t5_stall_seq", {31'b0, bus_b.o_wb_stall}, {31'b0, (c == 2 || c == 5)});
                if (bus_b.o_wb_stall) stalls++; else accs++;
                bus_b.i_wb_cyc = 1; bus_b.i_wb_stb = 1; bus_b.i_wb_we = 0;
                bus_b.i_wb_addr = 30'h8000 + 30'(c);
            end else bus_b.i_wb_stb = 0;
        end
        chk("t5_accepts", 32'(accs),   32'd4);
        chk("t5_acks",    32'(acks),   32'd4);
        chk("t5_stalls",  32'(stalls), 32'd2);
        @(negedge clk);
        bus_b.i_wb_cyc = 0;

        // 6: reset right after an accept drops the next one
        @(negedge clk);
        bus_a.i_wb_cyc = 1; bus_a.i_wb_stb = 1; bus_a.i_wb_we = 0; bus_a.i_wb_addr = 30'h8010;
        @(negedge clk);
        chk("t6_ack_before", {31'b0, bus_a.o_wb_ack}, 32'd1);
        chk("t6_data_before", bus_a.o_wb_data, 32'h11BB33DD);
        rst = 1; bus_a.i_wb_addr = 30'h8004;
        @(negedge clk);
        rst = 0; bus_a.i_wb_cyc = 0; bus_a.i_wb_stb = 0;
        chk("t6_ack",   {31'b0, bus_a.o_wb_ack},   32'd0);
        chk("t6_err",   {31'b0, bus_a.o_wb_err},   32'd0);
        chk("t6_stall", {31'b0, bus_a.o_wb_stall}, 32'd0);
        chk("t6_data",  bus_a.o_wb_data,           32'd0);
        @(negedge clk);
        chk("t6_ack_after",  {31'b0, bus_a.o_wb_ack}, 32'd0);
        chk("t6_data_after", bus_a.o_wb_data,         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
